// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encodings,
// parity modes and the baud-rate table with its divisor helper.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_START = 3'd1;
    localparam state_t ST_DATA  = 3'd2;
    localparam state_t ST_PAR   = 3'd3;
    localparam state_t ST_STOP  = 3'd4;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    function automatic int unsigned baud_rate(input int unsigned sel);
        case (sel)
            0:       return 115200;
            1:       return 57600;
            2:       return 38400;
            3:       return 19200;
            4:       return 9600;
            5:       return 230400;
            6:       return 460800;
            default: return 921600;
        endcase
    endfunction

    // Rounded clk/baud ratio, evaluated at elaboration only.
    function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned sel);
        longint unsigned b;
        longint unsigned num;
        b   = 64'(baud_rate(sel));
        num = 64'(clk_hz) + (b / 64'd2);
        return 32'(num / b);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered full/empty flags and an
// occupancy count; writes while full are ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [W-1:0]             wr_data,
    input  logic                     rd_en,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          do_wr, do_rd;

    always_comb begin
        do_wr    = wr_en && !full_q;
        do_rd    = rd_en && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        // Power-of-two depth lets the pointers wrap naturally.
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        full_d  = (level_d == DEPTH_L);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;
    assign level   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed serialiser with selectable baud,
// data width, parity and stop bits; queued frames go out back to back.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter int          PARITY     = 0,
    parameter int          STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [2:0]                    baud_set,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          txd,
    output logic                          busy,
    output logic                          tx_done
);

    // Slowest rate (9600) sets the counter width.
    localparam int CNT_W = $clog2(baud_div(CLK_HZ, 32'd4) + 32'd1);

    logic [CNT_W-1:0] div_tab [8];

    for (genvar g = 0; g < 8; g++) begin : g_div
        assign div_tab[g] = CNT_W'(baud_div(CLK_HZ, g));
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic             par_q, par_d;
    logic             txd_q, txd_d;
    logic             busy_q, busy_d;
    logic             stop_end_q, stop_end_d;
    logic             tx_done_q, tx_done_d;
    logic             overflow_q, overflow_d;

    logic              pop;
    logic              load;
    logic              bit_tick;
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_full, fifo_empty;

    // Host handshake: wr_data is taken on any cycle with wr_en=1 and full=0;
    // a write while full is dropped and flagged on overflow the next cycle.
    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        stop_end_d = 1'b0;
        load       = 1'b0;
        bit_tick   = (baud_cnt_q == (div_q - CNT_W'(1)));
        baud_cnt_d = bit_tick ? '0 : baud_cnt_q + CNT_W'(1);

        case (state_q)
            ST_IDLE: begin
                baud_cnt_d = '0;
                if (!fifo_empty) load = 1'b1;
            end
            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == 4'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_PAR: begin
                if (bit_tick) begin
                    state_d   = ST_STOP;
                    bit_cnt_d = '0;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
                        stop_end_d = 1'b1;
                        if (!fifo_empty) load = 1'b1;
                        else             state_d = ST_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Baud and parity are fixed per frame at the moment the word is popped.
        if (load) begin
            state_d    = ST_START;
            shift_d    = fifo_data;
            div_d      = div_tab[baud_set];
            par_d      = (^fifo_data) ^ (PARITY == PAR_ODD);
            baud_cnt_d = '0;
            bit_cnt_d  = '0;
        end
        pop = load;

        case (state_q)
            ST_START: txd_d = 1'b0;
            ST_DATA:  txd_d = shift_q[0];
            ST_PAR:   txd_d = par_q;
            default:  txd_d = 1'b1;
        endcase
        busy_d     = (state_q != ST_IDLE);
        tx_done_d  = stop_end_q;
        overflow_d = wr_en && fifo_full;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            div_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            stop_end_q <= 1'b0;
            tx_done_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            div_q      <= div_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            stop_end_q <= stop_end_d;
            tx_done_q  <= tx_done_d;
            overflow_q <= overflow_d;
        end
    end

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign overflow = overflow_q;
    assign txd      = txd_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three parameterisations share one stimulus stream;
// a frame-level reference model predicts every output on every cycle.
module tb_uart_tx_fifo;

  localparam int unsigned CLK0 = 50_000_000;
  localparam int unsigned CLK1 = 2_000_000;
  localparam int unsigned CLK2 = 2_000_000;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [8:0] wr_data;
  logic [2:0] baud_set;

  logic       full0, empty0, ovf0, txd0, busy0, done0;
  logic [4:0] level0;
  logic       full1, empty1, ovf1, txd1, busy1, done1;
  logic [2:0] level1;
  logic       full2, empty2, ovf2, txd2, busy2, done2;
  logic [3:0] level2;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_HZ(CLK0), .DATA_W(8), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u_def (
    .clk(clk), .reset(rst), .baud_set(baud_set), .wr_en(wr_en), .wr_data(wr_data[7:0]),
    .full(full0), .empty(empty0), .level(level0), .overflow(ovf0),
    .txd(txd0), .busy(busy0), .tx_done(done0));

  uart_tx_fifo #(.CLK_HZ(CLK1), .DATA_W(8), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(2)) u_odd (
    .clk(clk), .reset(rst), .baud_set(baud_set), .wr_en(wr_en), .wr_data(wr_data[7:0]),
    .full(full1), .empty(empty1), .level(level1), .overflow(ovf1),
    .txd(txd1), .busy(busy1), .tx_done(done1));

  uart_tx_fifo #(.CLK_HZ(CLK2), .DATA_W(9), .FIFO_DEPTH(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .reset(rst), .baud_set(baud_set), .wr_en(wr_en), .wr_data(wr_data),
    .full(full2), .empty(empty2), .level(level2), .overflow(ovf2),
    .txd(txd2), .busy(busy2), .tx_done(done2));

  logic       o_txd [3];
  logic       o_busy [3];
  logic       o_done [3];
  logic       o_ovf [3];
  logic       o_full [3];
  logic       o_empty [3];
  logic [7:0] o_level [3];

  assign o_txd[0] = txd0;   assign o_txd[1] = txd1;   assign o_txd[2] = txd2;
  assign o_busy[0] = busy0; assign o_busy[1] = busy1; assign o_busy[2] = busy2;
  assign o_done[0] = done0; assign o_done[1] = done1; assign o_done[2] = done2;
  assign o_ovf[0] = ovf0;   assign o_ovf[1] = ovf1;   assign o_ovf[2] = ovf2;
  assign o_full[0] = full0; assign o_full[1] = full1; assign o_full[2] = full2;
  assign o_empty[0] = empty0; assign o_empty[1] = empty1; assign o_empty[2] = empty2;
  assign o_level[0] = 8'(level0); assign o_level[1] = 8'(level1); assign o_level[2] = 8'(level2);

  // Per-instance configuration as seen by the model.
  int unsigned p_clk [3] = '{CLK0, CLK1, CLK2};
  int          p_dw [3] = '{8, 8, 9};
  int          p_depth [3] = '{16, 4, 8};
  int          p_par [3] = '{0, 1, 2};
  int          p_stop [3] = '{1, 2, 1};

  // Model: queued words, and the expected txd waveform per cycle
  // (bit 0 = line level, bit 1 = final cycle of a frame).
  int unsigned m_words [3][$];
  logic [1:0]  m_wave [3][$];
  bit          m_prev_last [3];

  int errors = 0;
  int checks = 0;
  int done_cnt [3];
  int ovf_cnt [3];

  function automatic int unsigned rate(input int unsigned s);
    case (s)
      0: return 115200;
      1: return 57600;
      2: return 38400;
      3: return 19200;
      4: return 9600;
      5: return 230400;
      6: return 460800;
      default: return 921600;
    endcase
  endfunction

  task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s[%0d]: got %0h expected %0h", tag, i, got, exp);
    end
  endtask

  task automatic build_frame(input int i, input int unsigned w, input int unsigned sel);
    longint unsigned div;
    int ones;
    bit bits [$];
    div = (longint'(p_clk[i]) + longint'(rate(sel) / 2)) / longint'(rate(sel));
    ones = 0;
    bits.push_back(1'b0);
    for (int b = 0; b < p_dw[i]; b++) begin
      bits.push_back(((w >> b) & 1) != 0);
      ones += int'((w >> b) & 1);
    end
    if (p_par[i] == 2) bits.push_back((ones % 2) == 1);
    if (p_par[i] == 1) bits.push_back((ones % 2) == 0);
    for (int s = 0; s < p_stop[i]; s++) bits.push_back(1'b1);
    for (int k = 0; k < bits.size(); k++)
      for (longint c = 0; c < longint'(div); c++)
        m_wave[i].push_back({(k == bits.size() - 1) && (c == longint'(div) - 1), bits[k]});
  endtask

  task automatic model_step(input int i, input bit r, input bit we, input int unsigned wd, input int unsigned sel);
    logic [1:0] e;
    bit x_txd, x_busy, x_done, x_ovf, can_pop, full_before;
    int unsigned w;
    if (r) begin
      m_words[i].delete();
      m_wave[i].delete();
      m_prev_last[i] = 1'b0;
      x_txd = 1'b1; x_busy = 1'b0; x_done = 1'b0; x_ovf = 1'b0;
    end else begin
      x_done = m_prev_last[i];
      can_pop = (m_words[i].size() != 0) && (m_wave[i].size() <= 1);
      full_before = (m_words[i].size() == p_depth[i]);
      if (m_wave[i].size() != 0) begin
        e = m_wave[i].pop_front();
        x_txd = e[0]; x_busy = 1'b1; m_prev_last[i] = e[1];
      end else begin
        x_txd = 1'b1; x_busy = 1'b0; m_prev_last[i] = 1'b0;
      end
      if (can_pop) begin
        w = m_words[i].pop_front();
        build_frame(i, w, sel);
      end
      x_ovf = we && full_before;
      if (we && !full_before) m_words[i].push_back(wd & ((32'd1 << p_dw[i]) - 32'd1));
    end
    check("txd", i, 32'(o_txd[i]), 32'(x_txd));
    check("busy", i, 32'(o_busy[i]), 32'(x_busy));
    check("tx_done", i, 32'(o_done[i]), 32'(x_done));
    check("overflow", i, 32'(o_ovf[i]), 32'(x_ovf));
    check("level", i, 32'(o_level[i]), 32'(m_words[i].size()));
    check("full", i, 32'(o_full[i]), 32'(m_words[i].size() == p_depth[i]));
    check("empty", i, 32'(o_empty[i]), 32'(m_words[i].size() == 0));
  endtask

  // One clock: inputs held across the edge, outputs checked 1 time unit later.
  task automatic tick();
    bit r, we;
    int unsigned wd, sel;
    r = rst; we = wr_en; wd = 32'(wr_data); sel = 32'(baud_set);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(i, r, we, wd, sel);
      if (o_done[i] === 1'b1) done_cnt[i]++;
      if (o_ovf[i] === 1'b1) ovf_cnt[i]++;
    end
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < 3; i++)
      if (m_words[i].size() != 0 || m_wave[i].size() != 0 || m_prev_last[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", 0, 32'(all_idle()), 32'd1);
    tick();
    tick();
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 3; i++) begin
      done_cnt[i] = 0;
      ovf_cnt[i] = 0;
    end
  endtask

  task automatic write_word(input int unsigned d);
    wr_en = 1'b1;
    wr_data = 9'(d);
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    int t;
    int n;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; baud_set = 3'd0;
    clear_counts();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single 0x99 frame: 2-cycle latency, 4340-cycle frame at 434 cycles/bit.
    write_word(32'h099);
    t = 0;
    while (o_txd[0] !== 1'b0 && t < 10) begin tick(); t++; end
    check("start_latency", 0, 32'(t), 32'd2);
    t = 0;
    while (o_done[0] !== 1'b1 && t < 6000) begin tick(); t++; end
    check("frame_len", 0, 32'(t), 32'd4340);
    check("busy_fall", 0, 32'(o_busy[0]), 32'd0);
    wait_idle(20000);

    // Three back-to-back words.
    clear_counts();
    write_word(32'h001);
    write_word(32'h002);
    write_word(32'h003);
    wait_idle(20000);
    for (int i = 0; i < 3; i++) check("done_count3", i, 32'(done_cnt[i]), 32'd3);

    // Baud change mid-frame affects only the following frame.
    write_word(32'h055);
    write_word(32'h0AA);
    repeat (5) tick();
    baud_set = 3'd5;
    wait_idle(20000);

    // Overflow: 18 consecutive writes into the 16-deep instance.
    baud_set = 3'd7;
    clear_counts();
    wr_en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      wr_data = 9'($urandom_range(0, 511));
      tick();
    end
    wr_en = 1'b0;
    wait_idle(30000);
    check("ovf_count", 0, 32'(ovf_cnt[0]), 32'd1);
    check("done_count17", 0, 32'(done_cnt[0]), 32'd17);

    // Random bursts with random gaps and baud changes among the fast rates.
    for (int b = 0; b < 6; b++) begin
      baud_set = 3'($urandom_range(6, 7));
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        wr_en = 1'b1;
        wr_data = 9'($urandom_range(0, 511));
        tick();
        wr_en = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
        if ($urandom_range(0, 1) == 1) baud_set = 3'($urandom_range(6, 7));
      end
      wait_idle(30000);
    end

    // Reset in the middle of a queued stream.
    baud_set = 3'd0;
    wr_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_data = 9'(32'h0F0 + k);
      tick();
    end
    wr_en = 1'b0;
    repeat (1500) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_txd", 0, 32'(o_txd[0]), 32'd1);
    check("rst_busy", 0, 32'(o_busy[0]), 32'd0);
    check("rst_level", 0, 32'(o_level[0]), 32'd0);
    clear_counts();
    repeat (500) tick();
    check("rst_no_done", 0, 32'(done_cnt[0]), 32'd0);
    write_word(32'h03C);
    wait_idle(20000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
